// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port unified-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MEM_LATENCY_DEF = 1;
    localparam int MAX_BURST_DEF   = 4;
    localparam int STAT_W          = 32;

    // Arbiter state doubles as "who owned the memory last cycle".
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DMA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Fixed-latency read-tag pipe: tracks which requester issued each granted read
// and raises that side's rvalid when the memory data comes back.
module mem_arb_rd_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t i_tag,
    output logic    o_core_rvalid,
    output logic    o_dma_rvalid
);

    rd_tag_t r_pipe [MEM_LATENCY];

    // NOTE: the tag pipe is cleared on reset (unlike a data RAM) so reads that
    // were in flight when reset hit never surface as rvalid afterwards.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_core_rvalid = r_pipe[MEM_LATENCY-1].valid && (r_pipe[MEM_LATENCY-1].owner == OWN_CORE);
    assign o_dma_rvalid  = r_pipe[MEM_LATENCY-1].valid && (r_pipe[MEM_LATENCY-1].owner == OWN_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// Core/DMA arbiter for the unified instruction/data memory with burst capping.
// Optional grant/contention counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int MAX_BURST   = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_core_grants,
    output logic [STAT_W-1:0] stat_dma_grants,
    output logic [STAT_W-1:0] stat_contention
`endif
);

    localparam int                BEAT_W   = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    arb_state_t        r_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_core_win;
    logic              w_dma_win;
    logic              w_burst_open;
    rd_tag_t           w_push_tag;

    assign w_burst_open = (r_beat_cnt < BEAT_MAX);

    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        w_core_win = 1'b0;
        w_dma_win  = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                CORE: begin
                    if (core_req && (w_burst_open || !dma_req)) w_core_win = 1'b1;
                    else if (dma_req)                           w_dma_win  = 1'b1;
                end
                DMA: begin
                    if (dma_req && (w_burst_open || !core_req)) w_dma_win  = 1'b1;
                    else if (core_req)                          w_core_win = 1'b1;
                end
                default: begin
                    if (core_req)     w_core_win = 1'b1;
                    else if (dma_req) w_dma_win  = 1'b1;
                end
            endcase
        end
    end

    assign core_gnt  = w_core_win;
    assign dma_gnt   = w_dma_win;
    assign mem_en    = w_core_win | w_dma_win;
    assign mem_we    = (w_core_win & core_we) | (w_dma_win & dma_we);
    assign mem_addr  = w_core_win ? core_addr  : (w_dma_win ? dma_addr  : '0);
    assign mem_wdata = w_core_win ? core_wdata : (w_dma_win ? dma_wdata : '0);
    assign rdata     = mem_rdata;

    assign w_beat_inc = (r_beat_cnt == BEAT_MAX) ? BEAT_MAX : r_beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else if (w_core_win) begin
            r_state    <= CORE;
            r_beat_cnt <= (r_state == CORE) ? w_beat_inc : BEAT_ONE;
        end else if (w_dma_win) begin
            r_state    <= DMA;
            r_beat_cnt <= (r_state == DMA) ? w_beat_inc : BEAT_ONE;
        end else begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end
    end

    assign w_push_tag.valid = mem_en && !mem_we;
    assign w_push_tag.owner = w_dma_win ? OWN_DMA : OWN_CORE;

    mem_arb_rd_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_rd_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tag         (w_push_tag),
        .o_core_rvalid (core_rvalid),
        .o_dma_rvalid  (dma_rvalid)
    );

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_core;
    logic [STAT_W-1:0] r_stat_dma;
    logic [STAT_W-1:0] r_stat_cont;

    // Both requesting always means exactly one of them lost the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_core <= '0;
            r_stat_dma  <= '0;
            r_stat_cont <= '0;
        end else begin
            if (w_core_win && (r_stat_core != '1)) r_stat_core <= r_stat_core + 1'b1;
            if (w_dma_win && (r_stat_dma != '1))   r_stat_dma  <= r_stat_dma + 1'b1;
            if (core_req && dma_req && mem_en && (r_stat_cont != '1))
                r_stat_cont <= r_stat_cont + 1'b1;
        end
    end

    assign stat_core_grants = r_stat_core;
    assign stat_dma_grants  = r_stat_dma;
    assign stat_contention  = r_stat_cont;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reference arbitration model plus a
// read-response scoreboard; a second instance with MEM_LATENCY=2 covers mid-flight reset.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MB   = 4;
    localparam int LAT  = 1;
    localparam int LAT2 = 2;

    localparam int N_NONE = 0;
    localparam int N_CORE = 1;
    localparam int N_DMA  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req, core_we, dma_req, dma_we;
    logic [AW-1:0] core_addr, dma_addr;
    logic [DW-1:0] core_wdata, dma_wdata;
    logic          core_gnt, core_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    logic          core_gnt_2, core_rvalid_2, dma_gnt_2, dma_rvalid_2;
    logic          mem_en_2, mem_we_2;
    logic [AW-1:0] mem_addr_2;
    logic [DW-1:0] mem_wdata_2, rdata_2;
    logic [DW-1:0] mem_rdata_2 = 32'h1234_5678;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_core_grants, stat_dma_grants, stat_contention;
    logic [31:0] stat_core_grants_2, stat_dma_grants_2, stat_contention_2;
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_BURST(MB)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_core_grants(stat_core_grants), .stat_dma_grants(stat_dma_grants),
        .stat_contention(stat_contention)
`endif
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT2), .MAX_BURST(MB)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_2), .core_rvalid(core_rvalid_2),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt_2), .dma_rvalid(dma_rvalid_2),
        .rdata(rdata_2), .mem_en(mem_en_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2),
        .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata_2)
`ifdef MEM_ARB_STATS_EN
        , .stat_core_grants(stat_core_grants_2), .stat_dma_grants(stat_dma_grants_2),
        .stat_contention(stat_contention_2)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Single-cycle-latency memory model; contents seeded on the first clock.
    logic [31:0] mem_model [256];
    bit          mem_filled = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_filled) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'hC0DE_0000 | 32'(i);
            mem_filled <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem_model[mem_addr[9:2]] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[9:2]];
    end

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } exp_rd_t;

    exp_rd_t sb_q[$];
    int      m_last = N_NONE;
    int      m_beat = 0;

    // Reference model and scoreboard, evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin : monitor
        int          win;
        logic        exp_we, exp_crv, exp_drv;
        logic [31:0] exp_addr, exp_wdata;
        exp_rd_t     ent;
        #2;
        if (!rst_n) begin
            m_last = N_NONE;
            m_beat = 0;
            sb_q.delete();
        end else begin
            win = N_NONE;
            case (m_last)
                N_CORE:  if (dma_req && (!core_req || m_beat >= MB)) win = N_DMA;
                         else if (core_req) win = N_CORE;
                N_DMA:   if (core_req && (!dma_req || m_beat >= MB)) win = N_CORE;
                         else if (dma_req) win = N_DMA;
                default: if (core_req) win = N_CORE;
                         else if (dma_req) win = N_DMA;
            endcase
            exp_we    = (win == N_CORE) ? core_we    : (win == N_DMA) ? dma_we    : 1'b0;
            exp_addr  = (win == N_CORE) ? core_addr  : (win == N_DMA) ? dma_addr  : 32'h0;
            exp_wdata = (win == N_CORE) ? core_wdata : (win == N_DMA) ? dma_wdata : 32'h0;

            check("core_gnt", 32'(core_gnt), 32'(win == N_CORE));
            check("dma_gnt", 32'(dma_gnt), 32'(win == N_DMA));
            check("mem_en", 32'(mem_en), 32'(win != N_NONE));
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, exp_wdata);

            exp_crv = 1'b0;
            exp_drv = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                ent     = sb_q.pop_front();
                exp_crv = (ent.owner == N_CORE);
                exp_drv = (ent.owner == N_DMA);
                check("rdata", rdata, ent.data);
            end
            check("core_rvalid", 32'(core_rvalid), 32'(exp_crv));
            check("dma_rvalid", 32'(dma_rvalid), 32'(exp_drv));

            if (win != N_NONE && !exp_we) begin
                ent.owner = win;
                ent.data  = mem_model[exp_addr[9:2]];
                ent.due   = cyc + LAT;
                sb_q.push_back(ent);
            end

            if (win == N_NONE) begin
                m_last = N_NONE;
                m_beat = 0;
            end else if (win == m_last) begin
                if (m_beat < MB) m_beat++;
            end else begin
                m_last = win;
                m_beat = 1;
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req  = dr; dma_we  = dw; dma_addr  = da; dma_wdata  = dd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_quiet(input string tag, input logic cg, input logic dg, input logic crv,
                               input logic drv, input logic en, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd);
        check({tag, "_ctl"}, {26'b0, cg, dg, crv, drv, en, we}, 32'h0);
        check({tag, "_addr"}, addr, 32'h0);
        check({tag, "_wdata"}, wd, 32'h0);
    endtask

    initial begin
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;

        // Reset state, with requests asserted to show grants are held off.
        repeat (3) @(negedge clk);
        core_req = 1'b1; dma_req = 1'b1; core_addr = 32'h44; dma_addr = 32'h88;
        #1;
        check_quiet("reset", core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
        check("reset_state", 32'(u_dut.r_state), 32'(IDLE));
`ifdef MEM_ARB_STATS_EN
        check("reset_stats", stat_core_grants | stat_dma_grants | stat_contention, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        core_req = 1'b0; dma_req = 1'b0; core_addr = '0; dma_addr = '0;

        // Both sides hold requests from IDLE: core reads, DMA writes, bursts of MB.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
`ifdef MEM_ARB_STATS_EN
            if (i == 8) begin
                #3;
                check("stat_core", stat_core_grants, 32'd4);
                check("stat_dma", stat_dma_grants, 32'd4);
                check("stat_cont", stat_contention, 32'd8);
            end
`endif
        end
        idle(2);

        // DMA write with no core traffic, then read it back from the core side.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        idle(1);
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);

        // Core-only read.
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);

        // Interleaved reads core, DMA, core on consecutive cycles.
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Random traffic, including requests that drop before being granted.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
        end
        idle(3);

        // Reset one cycle after a granted read; the latency-2 instance still has it in flight.
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        #3;
        rst_n = 1'b0;
        core_req = 1'b1; dma_req = 1'b1; core_addr = 32'h30; dma_addr = 32'h34;
        #1;
        check_quiet("rst_mid", core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
        check_quiet("rst_mid2", core_gnt_2, dma_gnt_2, core_rvalid_2, dma_rvalid_2, mem_en_2, mem_we_2,
                    mem_addr_2, mem_wdata_2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        core_req = 1'b0; dma_req = 1'b0; core_addr = '0; dma_addr = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("post_rst_rvalid2", {30'b0, core_rvalid_2, dma_rvalid_2}, 32'h0);
        end
        check("post_rst_state2", 32'(u_dut2.r_state), 32'(IDLE));

        idle(3);
        #3;
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters:
  - the multicycle core's memory port (driven by fetch/load/store sequencing);
  - a DMA/loader port used for program load and debug access.
- Grants at most one access per cycle, combinationally, on request.
- Caps back-to-back bursts so neither side starves.
- Returns read data with fixed latency, tagged to the issuing requester.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from granted read to valid mem_rdata (>=1)
- MAX_BURST, 4, max consecutive grants to one owner while the other side is requesting (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- core_req  in  1  core access request; held until core_gnt
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access accepted this cycle (core stalls while low)
- core_rvalid  out  1  core read data valid
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid  same as the core_* ports, for the DMA side
- rdata  out  DATA_W  read data, shared by both sides; qualified by *_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, MEM_LATENCY cycles after mem_en with mem_we=0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, beat_cnt=0, read-tag pipe cleared;
  - core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we = 0;
  - mem_addr, mem_wdata = 0.
- Grants are combinational from the current requests and registered state. They are forced to 0 while rst_n=0.
- Exactly one grant per cycle at most; a grant is given only to an asserted request.
- Memory outputs are muxed from the winner. With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE (no grant last cycle), CORE (core granted last cycle), DMA (DMA granted last cycle).
- IDLE: core_req -> grant core. Otherwise dma_req -> grant DMA. Otherwise nothing.
- CORE:
  - grant core if core_req and (beat_cnt<MAX_BURST or !dma_req);
  - else grant DMA if dma_req;
  - else no grant.
- DMA: symmetric to CORE with the roles swapped.
- Next state: the owner of this cycle's grant; IDLE if nothing was granted.
- beat_cnt:
  - same owner as last cycle -> increment, saturating at MAX_BURST;
  - new owner -> 1;
  - no grant -> 0.
- Writes complete on grant; no response is generated.
- Granted read: push {valid=1, owner} into a MEM_LATENCY-deep shift pipe. Every other cycle pushes valid=0.
  - Pipe tail valid with owner=core -> core_rvalid=1.
  - Pipe tail valid with owner=DMA -> dma_rvalid=1.
  - rdata = mem_rdata, passed through combinationally.
- Back-to-back reads from alternating owners are legal. Responses return in issue order, one per cycle.
- Simultaneous first requests after IDLE: core wins.
- Request dropped before grant: legal; no side effects.
- Reset mid-operation: in-flight read tags are discarded. No rvalid is asserted for them after reset release.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined, adds three outputs, each 32-bit saturating, cleared on reset:
  - stat_core_grants: counts core grants;
  - stat_dma_grants: counts DMA grants;
  - stat_contention: counts cycles where both requests are high and one is denied.
- Undefined, the ports and counters do not exist. Arbitration is identical either way.

Decomposition:
- Package mem_arb_pkg:
  - owner/state enum (IDLE, CORE, DMA);
  - owner tag typedef;
  - rd_tag_t struct {valid, owner};
  - default width constants.
- One sub-module, mem_arb_rd_pipe: parameterized MEM_LATENCY shift register of rd_tag_t with async active-low clear. It produces core_rvalid/dma_rvalid.
- Arbitration FSM and beat counter stay in mem_arbiter.

Test Plan:
1. Core-only read, addr 0x10, MEM_LATENCY=1:
   - core_gnt=1 in cycle 0, mem_en=1, mem_we=0, mem_addr=0x10;
   - core_rvalid=1 in cycle 1 with rdata=mem_rdata; dma_rvalid stays 0.
2. Both request from IDLE:
   - core granted first;
   - with both held, core gets 4 consecutive grants (MAX_BURST=4), then DMA gets 4, alternating.
3. DMA write 0xDEADBEEF to 0x200 with no core request:
   - dma_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF in the same cycle;
   - no rvalid on either side.
4. Interleaved reads core@0x0, DMA@0x4, core@0x8 on consecutive cycles:
   - rvalids arrive as core, dma, core in the next three cycles.
5. Assert rst_n=0 one cycle after a granted read (MEM_LATENCY=2):
   - all outputs 0 immediately;
   - no rvalid after release; state IDLE.
6. With MEM_ARB_STATS_EN, run scenario 2 for 8 cycles:
   - stat_core_grants=4, stat_dma_grants=4, stat_contention=8.
